// File: rtl/pow_share_arb.sv
// Round-robin arbiter/sequencer sharing one iterative x^n power unit among NREQ requesters.
// Operands are latched at grant; a watchdog aborts a transaction whose unit never returns ready.
module pow_share_arb #(
    parameter int NREQ    = 4,
    parameter int XW      = 16,
    parameter int NW      = 8,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int WDW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*NW-1:0] req_n,
    output logic [NREQ-1:0]    ack,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [XW-1:0]      resp_data,
    output logic               resp_err,
    output logic               busy,
    output logic               pu_start,
    output logic [XW-1:0]      pu_x,
    output logic [NW-1:0]      pu_n,
    input  logic               pu_ready,
    input  logic [XW-1:0]      pu_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_sel;
    logic [WDW-1:0]     r_wdog;
    logic [NREQ-1:0]    r_ack;
    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic [XW-1:0]      r_resp_data;
    logic               r_resp_err;
    logic               r_busy;
    logic               r_pu_start;
    logic [XW-1:0]      r_pu_x;
    logic [NW-1:0]      r_pu_n;

    logic               w_any;
    logic [IDW-1:0]     w_sel;
    logic [IDW-1:0]     w_ptr_next;

    // Scan downward in offset so the requester closest above the pointer wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_sel = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (req[idx]) begin
                w_any = 1'b1;
                w_sel = IDW'(idx);
            end
        end
    end

    assign w_ptr_next = IDW'((int'(r_sel) + 1) % NREQ);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_wdog       <= '0;
            r_ack        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_pu_start   <= 1'b0;
            r_pu_x       <= '0;
            r_pu_n       <= '0;
        end else begin
            r_ack        <= '0;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel      <= w_sel;
                        r_pu_x     <= req_x[int'(w_sel)*XW +: XW];
                        r_pu_n     <= req_n[int'(w_sel)*NW +: NW];
                        r_pu_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // A unit still busy from an aborted run keeps us here until it frees up.
                    if (pu_ready) begin
                        r_pu_start <= 1'b0;
                        r_wdog     <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pu_ready || (r_wdog == WDW'(TIMEOUT - 1))) begin
                        r_resp_data  <= pu_ready ? pu_out : '0;
                        r_resp_err   <= ~pu_ready;
                        r_ack        <= NREQ'(1) << r_sel;
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_sel;
                        r_state      <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= w_ptr_next;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;
    assign pu_start   = r_pu_start;
    assign pu_x       = r_pu_x;
    assign pu_n       = r_pu_n;

endmodule

// File: tb/tb_pow_share_arb.sv
// Directed bench for pow_share_arb with a behavioural power unit that can be made to hang.
module tb_pow_share_arb;

    localparam int NREQ    = 4;
    localparam int XW      = 16;
    localparam int NW      = 8;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               nrst;
    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ-1:0]    ack;
    logic               resp_valid;
    logic [1:0]         resp_id;
    logic [XW-1:0]      resp_data;
    logic               resp_err;
    logic               busy;
    logic               pu_start;
    logic [XW-1:0]      pu_x;
    logic [NW-1:0]      pu_n;
    logic               pu_ready;
    logic [XW-1:0]      pu_out;

    logic               hang;
    logic [3:0]         u_cnt;
    int                 total;
    int                 bad;

    pow_share_arb #(.NREQ(NREQ), .XW(XW), .NW(NW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .req_x      (req_x),
        .req_n      (req_n),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .pu_start   (pu_start),
        .pu_x       (pu_x),
        .pu_n       (pu_n),
        .pu_ready   (pu_ready),
        .pu_out     (pu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XW-1:0] pow_ref(input logic [XW-1:0] x, input logic [NW-1:0] n);
        logic [XW-1:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * x;
        return r;
    endfunction

    // Power unit stand-in: registered ready, busy for 1 + n[1:0] cycles, frozen while hang=1.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pu_ready <= 1'b1;
            u_cnt    <= '0;
            pu_out   <= '0;
        end else if (pu_ready && pu_start) begin
            pu_ready <= 1'b0;
            u_cnt    <= 4'd1 + {2'b00, pu_n[1:0]};
            pu_out   <= pow_ref(pu_x, pu_n);
        end else if (!pu_ready && !hang) begin
            if (u_cnt <= 4'd1) pu_ready <= 1'b1;
            else               u_cnt    <= u_cnt - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input int budget, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < budget && !seen) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) seen = 1'b1;
        end
    endtask

    task automatic set_ops(input int id, input logic [XW-1:0] x, input logic [NW-1:0] n);
        req_x[id*XW +: XW] = x;
        req_n[id*NW +: NW] = n;
    endtask

    task automatic do_req(input string tag, input int id, input logic [XW-1:0] x,
                          input logic [NW-1:0] n, input logic [XW-1:0] exp, input int exp_lat);
        int cyc;
        bit seen;
        set_ops(id, x, n);
        req[id] = 1'b1;
        wait_resp(200, cyc, seen);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_ack"},  32'(ack), 32'(4'b0001 << id));
            check({tag, "_id"},   32'(resp_id), 32'(id));
            check({tag, "_data"}, 32'(resp_data), 32'(exp));
            check({tag, "_err"},  32'(resp_err), 32'd0);
            if (exp_lat > 0) check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        end
        req[id] = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_ack_after"},  32'(ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc;
        int cnt;
        bit seen;
        logic [XW-1:0] rr_exp [NREQ];
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        hang  = 1'b0;
        req   = '0;
        req_x = '0;
        req_n = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_start", 32'(pu_start), 32'd0);
        check("rst_pu_x",  32'(pu_x), 32'd0);
        check("rst_data",  32'(resp_data), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        do_req("single", 0, 16'd3, 8'd4, 16'd81, 0);
        do_req("x2n0", 1, 16'd2, 8'd0, 16'd1, 4);
        do_req("x256n2", 2, 16'd256, 8'd2, 16'd0, 0);
        do_req("xffffn255", 0, 16'hFFFF, 8'd255, 16'hFFFF, 0);
        do_req("x0n0", 3, 16'd0, 8'd0, 16'd1, 4);

        // Pointer now sits at 0; hold all four requests for two full rounds.
        set_ops(0, 16'd3, 8'd5);   rr_exp[0] = 16'd243;
        set_ops(1, 16'd10, 8'd3);  rr_exp[1] = 16'd1000;
        set_ops(2, 16'd7, 8'd2);   rr_exp[2] = 16'd49;
        set_ops(3, 16'd2, 8'd10);  rr_exp[3] = 16'd1024;
        req = 4'hF;
        for (int g = 0; g < 2 * NREQ; g++) begin
            wait_resp(100, cyc, seen);
            check($sformatf("rr%0d_seen", g), 32'(seen), 32'd1);
            if (seen) begin
                check($sformatf("rr%0d_id", g),   32'(resp_id), 32'(g % NREQ));
                check($sformatf("rr%0d_ack", g),  32'(ack), 32'(4'b0001 << (g % NREQ)));
                check($sformatf("rr%0d_data", g), 32'(resp_data), 32'(rr_exp[g % NREQ]));
            end
        end
        req = '0;
        @(negedge clk);
        check("rr_busy_after", 32'(busy), 32'd0);

        set_ops(1, 16'd7, 8'd3);
        req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("stab_in_wait", 32'({busy, pu_start}), 32'b10);
        set_ops(1, 16'd9, 8'd5);
        wait_resp(100, cyc, seen);
        check("stab_seen", 32'(seen), 32'd1);
        check("stab_data", 32'(resp_data), 32'd343);
        req[1] = 1'b0;
        @(negedge clk);

        hang = 1'b1;
        set_ops(2, 16'd3, 8'd2);
        req[2] = 1'b1;
        wait_resp(TIMEOUT + 20, cyc, seen);
        check("wd_seen", 32'(seen), 32'd1);
        check("wd_lat",  32'(cyc), 32'(TIMEOUT + 2));
        check("wd_err",  32'(resp_err), 32'd1);
        check("wd_data", 32'(resp_data), 32'd0);
        check("wd_id",   32'(resp_id), 32'd2);
        req[2] = 1'b0;
        @(negedge clk);

        set_ops(3, 16'd5, 8'd2);
        req[3] = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        check("stuck_no_resp", 32'(cnt), 32'd0);
        check("stuck_launch",  32'({busy, pu_start}), 32'b11);
        check("stuck_pu_x",    32'(pu_x), 32'd5);
        hang = 1'b0;
        wait_resp(40, cyc, seen);
        check("recover_seen", 32'(seen), 32'd1);
        check("recover_data", 32'(resp_data), 32'd25);
        check("recover_err",  32'(resp_err), 32'd0);
        check("recover_id",   32'(resp_id), 32'd3);
        req[3] = 1'b0;
        @(negedge clk);

        set_ops(1, 16'd2, 8'd7);
        req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("arst_ack",   32'(ack), 32'd0);
        check("arst_valid", 32'(resp_valid), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_start", 32'(pu_start), 32'd0);
        check("arst_pu",    32'({pu_x, pu_n}), 32'd0);
        check("arst_resp",  32'({resp_data, resp_err, resp_id}), 32'd0);
        req = '0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || ack != '0) cnt++;
        end
        check("arst_no_ack", 32'(cnt), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        do_req("post_rst", 0, 16'd5, 8'd3, 16'd125, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
